// File: rtl/scan_seq16_pkg.sv
// Shared encodings for the scan sequencer: scan patterns and FSM states.
package scan_seq16_pkg;

    localparam logic [1:0] MODE_UP     = 2'b00;
    localparam logic [1:0] MODE_DOWN   = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;
    localparam logic [1:0] MODE_SINGLE = 2'b11;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // First select value of a scan: down mode starts at the top position.
    function automatic logic [3:0] start_w(input logic [1:0] mode);
        return (mode == MODE_DOWN) ? 4'd15 : 4'd0;
    endfunction

endpackage

// File: rtl/dec4to16.sv
// 4-to-16 one-hot decoder driven by the scan sequencer.
module dec4to16 (
    input  logic [3:0]  W,
    input  logic        En,
    output logic [15:0] Y
);

    // One-hot output for the selected position, all zero when disabled.
    always_comb begin
        Y = '0;
        if (En) Y = 16'd1 << W;
    end

endmodule

// File: rtl/scan_seq16_dwell_timer.sv
// Loadable down-counter timing the dwell at each scan position.
// zero is high when the count has reached 0; the count then holds until reloaded.
module dwell_timer #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 Clock,
    input  logic                 Resetn,
    input  logic                 load,
    input  logic [DIV_WIDTH-1:0] val,
    output logic                 zero
);

    logic [DIV_WIDTH-1:0] r_cnt;

    // Load has priority over counting down; saturate at zero.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign zero = (r_cnt == '0);

endmodule

// File: rtl/scan_seq16.sv
// Scan controller stepping the decoder select through 16 positions with a
// programmable dwell per position; up, down, bounce and single-shot patterns.
module scan_seq16
    import scan_seq16_pkg::*;
#(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 Clock,
    input  logic                 Resetn,
    input  logic                 Start,
    input  logic                 Stop,
    input  logic [1:0]           Mode,
    input  logic [DIV_WIDTH-1:0] Div,
    output logic [3:0]           W,
    output logic                 En,
    output logic                 Busy,
    output logic                 Done
);

    state_t     r_state, w_state;
    logic [1:0] r_mode,  w_mode;
    logic [3:0] r_w,     w_w;
    logic       r_dir,   w_dir;
    logic       r_en,    w_en;
    logic       r_busy,  w_busy;
    logic       r_done,  w_done;
    logic       w_load;
    logic       w_zero;

    // Dwell counter: reloaded from the live Div at scan start and at each advance.
    dwell_timer #(.DIV_WIDTH(DIV_WIDTH)) u_dwell (
        .Clock  (Clock),
        .Resetn (Resetn),
        .load   (w_load),
        .val    (Div),
        .zero   (w_zero)
    );

    // State and registered outputs; everything reset asynchronously to idle.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state <= S_IDLE;
            r_mode  <= MODE_UP;
            r_w     <= 4'd0;
            r_dir   <= 1'b0;
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_mode  <= w_mode;
            r_w     <= w_w;
            r_dir   <= w_dir;
            r_en    <= w_en;
            r_busy  <= w_busy;
            r_done  <= w_done;
        end
    end

    // Next-state, next-select and dwell reload decisions.
    always_comb begin
        w_state = r_state;
        w_mode  = r_mode;
        w_w     = r_w;
        w_dir   = r_dir;
        w_en    = r_en;
        w_busy  = r_busy;
        w_done  = 1'b0;
        w_load  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_w    = 4'd0;
                w_en   = 1'b0;
                w_busy = 1'b0;
                // Stop beats Start when both are high.
                if (Start && !Stop) begin
                    w_state = S_RUN;
                    w_mode  = Mode;
                    w_load  = 1'b1;
                    w_w     = start_w(Mode);
                    w_dir   = (Mode == MODE_DOWN);
                    w_en    = 1'b1;
                    w_busy  = 1'b1;
                end
            end
            S_RUN: begin
                if (Stop) begin
                    // Abort wins over everything, including single-shot completion.
                    w_state = S_IDLE;
                    w_w     = 4'd0;
                    w_en    = 1'b0;
                    w_busy  = 1'b0;
                end else if (w_zero) begin
                    w_load = 1'b1;
                    case (r_mode)
                        MODE_UP:   w_w = r_w + 4'd1;
                        MODE_DOWN: w_w = r_w - 4'd1;
                        MODE_BOUNCE: begin
                            // Turn around at either end without repeating the endpoint.
                            if (r_w == 4'd15) begin
                                w_dir = 1'b1;
                                w_w   = 4'd14;
                            end else if (r_w == 4'd0 && r_dir) begin
                                w_dir = 1'b0;
                                w_w   = 4'd1;
                            end else if (r_dir) begin
                                w_w = r_w - 4'd1;
                            end else begin
                                w_w = r_w + 4'd1;
                            end
                        end
                        default: begin
                            if (r_w == 4'd15) begin
                                w_state = S_IDLE;
                                w_load  = 1'b0;
                                w_w     = 4'd0;
                                w_en    = 1'b0;
                                w_busy  = 1'b0;
                                w_done  = 1'b1;
                            end else begin
                                w_w = r_w + 4'd1;
                            end
                        end
                    endcase
                end
            end
            default: begin
                w_state = S_IDLE;
                w_w     = 4'd0;
                w_en    = 1'b0;
                w_busy  = 1'b0;
            end
        endcase
    end

    assign W    = r_w;
    assign En   = r_en;
    assign Busy = r_busy;
    assign Done = r_done;

endmodule
